// File: rtl/detect_frame_sequencer.sv
// Frame sequencer: streams a buffered frame into the face detector, waits for its verdict
// and hands a clipped square ROI to the emotion stage.
module detect_frame_sequencer #(
   parameter int unsigned IMG_WIDTH      = 64,
   parameter int unsigned IMG_HEIGHT     = 64,
   parameter int unsigned PIXEL_WIDTH    = 8,
   parameter int unsigned ROI_SIZE       = 24,
   parameter int unsigned TIMEOUT_CYCLES = 65536,
   localparam int unsigned AW            = $clog2(IMG_WIDTH*IMG_HEIGHT)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   frame_ready,
   output logic                   frame_release,
   output logic                   mem_rd,
   output logic [AW-1:0]          mem_addr,
   input  logic [PIXEL_WIDTH-1:0] mem_data,
   output logic                   det_start,
   output logic [PIXEL_WIDTH-1:0] det_pixel,
   output logic                   det_pixel_valid,
   input  logic                   det_done,
   input  logic                   det_face,
   input  logic [7:0]             det_x,
   input  logic [7:0]             det_y,
   output logic                   roi_valid,
   input  logic                   roi_ready,
   output logic [7:0]             roi_x,
   output logic [7:0]             roi_y,
   output logic [7:0]             roi_w,
   output logic [7:0]             roi_h,
   output logic                   busy,
   output logic                   timeout_err,
   output logic [15:0]            frame_count
);

   localparam int unsigned NPIX  = IMG_WIDTH * IMG_HEIGHT;
   localparam int unsigned TW    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [8:0]  X_MAX = 9'(IMG_WIDTH - ROI_SIZE);
   localparam logic [8:0]  Y_MAX = 9'(IMG_HEIGHT - ROI_SIZE);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_STREAM, S_DRAIN, S_WAIT_DONE, S_REPORT
   } state_t;

   state_t        state, state_nxt;
   logic [TW-1:0] wait_cnt;
   logic          wait_expired_c;

   assign wait_expired_c = (wait_cnt == TW'(TIMEOUT_CYCLES - 1));

   // Read data arrives one cycle after the strobe, exactly when the delayed strobe is high.
   assign det_pixel = det_pixel_valid ? mem_data : '0;

   // Next-state decode
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:      if (frame_ready) state_nxt = S_START;
         S_START:     state_nxt = S_STREAM;
         S_STREAM:    if (mem_addr == AW'(NPIX - 1)) state_nxt = S_DRAIN;
         S_DRAIN:     state_nxt = S_WAIT_DONE;
         S_WAIT_DONE: begin
            if (det_done)            state_nxt = det_face ? S_REPORT : S_IDLE;
            else if (wait_expired_c) state_nxt = S_IDLE;
         end
         S_REPORT:    if (roi_ready) state_nxt = S_IDLE;
         default:     state_nxt = S_IDLE;
      endcase
   end

   // State and registered outputs; strobes are decoded from the next state so they line up with it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= S_IDLE;
         det_start       <= 1'b0;
         mem_rd          <= 1'b0;
         mem_addr        <= '0;
         det_pixel_valid <= 1'b0;
         frame_release   <= 1'b0;
         busy            <= 1'b0;
         roi_valid       <= 1'b0;
         roi_x           <= '0;
         roi_y           <= '0;
         roi_w           <= '0;
         roi_h           <= '0;
         wait_cnt        <= '0;
         timeout_err     <= 1'b0;
         frame_count     <= '0;
      end else begin
         state           <= state_nxt;
         det_start       <= (state_nxt == S_START);
         mem_rd          <= (state_nxt == S_STREAM);
         det_pixel_valid <= mem_rd;
         frame_release   <= (state_nxt == S_DRAIN);
         busy            <= (state_nxt != S_IDLE);
         roi_valid       <= (state_nxt == S_REPORT);
         mem_addr        <= (state == S_STREAM && state_nxt == S_STREAM) ? mem_addr + AW'(1) : '0;
         wait_cnt        <= (state == S_WAIT_DONE) ? wait_cnt + TW'(1) : '0;

         if (state_nxt == S_START)
            timeout_err <= 1'b0;
         else if (state == S_WAIT_DONE && !det_done && wait_expired_c)
            timeout_err <= 1'b1;

         if (state == S_WAIT_DONE && state_nxt != S_WAIT_DONE)
            frame_count <= frame_count + 16'd1;

         // Clip so the square ROI never runs past the frame edge
         if (state == S_WAIT_DONE && det_done && det_face) begin
            roi_x <= ({1'b0, det_x} > X_MAX) ? X_MAX[7:0] : det_x;
            roi_y <= ({1'b0, det_y} > Y_MAX) ? Y_MAX[7:0] : det_y;
            roi_w <= 8'(ROI_SIZE);
            roi_h <= 8'(ROI_SIZE);
         end
      end
   end

endmodule

// File: tb/tb_detect_frame_sequencer.sv
// Bench for detect_frame_sequencer: random frame content and detector answers, a queue-based
// scoreboard for pixels/ROIs, and cycle-exact checks of the frame handshake.
`timescale 1ns/1ps
module tb_detect_frame_sequencer;
   localparam int unsigned W    = 64;
   localparam int unsigned H    = 64;
   localparam int unsigned PW   = 8;
   localparam int unsigned RS   = 24;
   localparam int unsigned TO   = 65536;
   localparam int unsigned NPIX = W * H;
   localparam int unsigned AW   = $clog2(NPIX);

   logic          clk, rst, frame_ready, frame_release, mem_rd;
   logic [AW-1:0] mem_addr;
   logic [PW-1:0] mem_data, det_pixel;
   logic          det_start, det_pixel_valid, det_done, det_face;
   logic [7:0]    det_x, det_y, roi_x, roi_y, roi_w, roi_h;
   logic          roi_valid, roi_ready, busy, timeout_err;
   logic [15:0]   frame_count;

   logic [PW-1:0] frame_mem [NPIX];
   logic [PW-1:0] exp_pix [$];
   logic [15:0]   exp_roi [$];
   logic [15:0]   roi_e;
   int            vec = 0, errs = 0;
   longint        cyc = 0, last_v = 0;
   int            exp_addr = 0, pix_got = 0, rel_cnt = 0, exp_fc = 0;
   bit            roi_seen = 0;

   detect_frame_sequencer dut (
      .clk(clk), .rst(rst), .frame_ready(frame_ready), .frame_release(frame_release),
      .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data), .det_start(det_start),
      .det_pixel(det_pixel), .det_pixel_valid(det_pixel_valid), .det_done(det_done),
      .det_face(det_face), .det_x(det_x), .det_y(det_y), .roi_valid(roi_valid),
      .roi_ready(roi_ready), .roi_x(roi_x), .roi_y(roi_y), .roi_w(roi_w), .roi_h(roi_h),
      .busy(busy), .timeout_err(timeout_err), .frame_count(frame_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Synchronous frame buffer: data appears the cycle after the read strobe
   always @(posedge clk) if (mem_rd) mem_data <= frame_mem[mem_addr];

   task automatic check(input string name, input longint act, input longint exp);
      vec++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int clip(input int v, input int lim);
      return (v > lim) ? lim : v;
   endfunction

   function automatic logic outs_or();
      return |{frame_release, mem_rd, mem_addr, det_start, det_pixel, det_pixel_valid,
               roi_valid, roi_x, roi_y, roi_w, roi_h, busy, timeout_err, frame_count};
   endfunction

   // Monitor: address sequence, pixel scoreboard, ROI transfers
   always @(negedge clk) begin
      #1;
      if (frame_release) rel_cnt++;
      if (roi_valid) roi_seen = 1'b1;
      if (mem_rd) begin
         check("rd_addr", mem_addr, exp_addr);
         exp_addr++;
      end
      if (det_pixel_valid) begin
         if (pix_got > 0) check("pix_contig", cyc, last_v + 1);
         if (exp_pix.size() == 0) check("pix_q_empty", exp_pix.size(), 1);
         else check("pixel", det_pixel, exp_pix.pop_front());
         pix_got++;
         last_v = cyc;
      end
      if (roi_valid && roi_ready) begin
         if (exp_roi.size() == 0) check("roi_q_empty", exp_roi.size(), 1);
         else begin
            roi_e = exp_roi.pop_front();
            check("roi_x", roi_x, roi_e[15:8]);
            check("roi_y", roi_y, roi_e[7:0]);
            check("roi_w", roi_w, RS);
            check("roi_h", roi_h, RS);
         end
      end
   end

   task automatic load_frame();
      for (int i = 0; i < NPIX; i++) begin
         frame_mem[i] = PW'($urandom);
         exp_pix.push_back(frame_mem[i]);
      end
      exp_addr = 0; pix_got = 0; rel_cnt = 0; roi_seen = 1'b0;
   endtask

   task automatic wait_idle();
      int g = 0;
      while (busy && g < TO + 200) begin @(negedge clk); g++; end
   endtask

   task automatic run_frame(input bit face, input bit early, input bit tmo,
                            input int dx, input int dy, input int dly, input int hold);
      longint n, d;
      int g;
      wait_idle();
      load_frame();
      @(negedge clk); frame_ready = 1'b1; n = cyc;
      @(negedge clk); frame_ready = 1'b0;
      check("det_start", det_start, 1);
      @(negedge clk);
      check("first_rd", mem_rd, 1);
      @(negedge clk);
      check("first_valid", det_pixel_valid, 1);
      g = 0;
      while (!frame_release && g < NPIX + 10) begin
         det_done = early && (g == 100);
         det_face = det_done; det_x = 8'd5; det_y = 8'd5;
         @(negedge clk); g++;
      end
      det_done = 1'b0; det_face = 1'b0;
      check("release_cyc", cyc, n + 2 + NPIX);
      d = cyc;
      exp_fc++;
      if (tmo) begin
         g = 0;
         while (busy && g < TO + 100) begin @(negedge clk); g++; end
         check("timeout_cyc", cyc, d + TO + 1);
         check("timeout_err", timeout_err, 1);
      end else begin
         repeat (dly) @(negedge clk);
         det_done = 1'b1; det_face = face; det_x = 8'(dx); det_y = 8'(dy);
         if (face) exp_roi.push_back({8'(clip(dx, W - RS)), 8'(clip(dy, H - RS))});
         @(negedge clk);
         det_done = 1'b0; det_face = 1'b0;
         if (face) begin
            check("roi_valid_up", roi_valid, 1);
            for (int i = 0; i < hold; i++) begin
               frame_ready = 1'b1;
               check("hold_valid", roi_valid, 1);
               check("hold_x", roi_x, clip(dx, W - RS));
               check("hold_y", roi_y, clip(dy, H - RS));
               check("hold_no_start", det_start, 0);
               @(negedge clk);
            end
            frame_ready = 1'b0; roi_ready = 1'b1;
            @(negedge clk);
            roi_ready = 1'b0;
            check("roi_valid_down", roi_valid, 0);
         end else begin
            check("no_roi", roi_seen, 0);
         end
         check("back_idle", busy, 0);
         check("timeout_err_clr", timeout_err, 0);
      end
      check("frame_count", frame_count, exp_fc);
      check("pix_left", exp_pix.size(), 0);
      check("pix_count", pix_got, NPIX);
      check("release_cnt", rel_cnt, 1);
      if (!face) check("no_roi_valid", roi_seen, 0);
   endtask

   task automatic reset_mid_frame();
      int g = 0, rel0;
      wait_idle();
      load_frame();
      @(negedge clk); frame_ready = 1'b1;
      @(negedge clk); frame_ready = 1'b0;
      while (mem_addr != AW'(2000) && g < 3000) begin @(negedge clk); g++; end
      check("reach_2000", mem_addr, 2000);
      #2 rst = 1'b1;
      #1 check("rst_mid_outs", outs_or(), 0);
      exp_pix.delete();
      exp_fc = 0;
      rel0 = rel_cnt;
      @(negedge clk); rst = 1'b0;
      repeat (20) @(negedge clk);
      check("no_release_after_rst", rel_cnt, rel0);
      check("idle_after_rst", busy, 0);
   endtask

   initial begin
      rst = 1'b1; frame_ready = 1'b0; det_done = 1'b0; det_face = 1'b0;
      det_x = '0; det_y = '0; roi_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_outs", outs_or(), 0);
      rst = 1'b0;
      @(negedge clk);
      run_frame(1'b1, 1'b0, 1'b0, 10, 20, 100, 0);
      run_frame(1'b1, 1'b0, 1'b0, 50, 63, $urandom_range(1, 300), 50);
      reset_mid_frame();
      run_frame(1'b0, 1'b1, 1'b0, $urandom_range(0, 255), $urandom_range(0, 255),
                $urandom_range(1, 500), 0);
      run_frame(1'b0, 1'b0, 1'b1, 0, 0, 0, 0);
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end
endmodule

// File: doc/detect_frame_sequencer.md
DETECT_FRAME_SEQUENCER -- requirements
Module: detect_frame_sequencer

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning:
- IMG_WIDTH, 64, frame width in pixels
- IMG_HEIGHT, 64, frame height in pixels
- PIXEL_WIDTH, 8, pixel bit width
- ROI_SIZE, 24, square ROI edge reported downstream
- TIMEOUT_CYCLES, 65536, maximum wait for detector done
REQ-002 SHALL have ports, one per line: name direction width meaning:
- clk in 1: single clock, all logic on rising edge
- rst in 1: reset, asynchronous, active-high
- frame_ready in 1: frame buffer holds a complete frame
- frame_release out 1: one-cycle pulse, frame buffer may be overwritten
- mem_rd out 1: frame buffer read strobe
- mem_addr out AW = $clog2(IMG_WIDTH*IMG_HEIGHT): raster read address
- mem_data in PIXEL_WIDTH: read data, valid the cycle after mem_rd
- det_start out 1: one-cycle start pulse to face_detector
- det_pixel out PIXEL_WIDTH: pixel to face_detector
- det_pixel_valid out 1: det_pixel qualifier
- det_done in 1: face_detector finished
- det_face in 1: face_detector face_detected
- det_x, det_y in 8: face_detector face coordinates
- roi_valid out 1: ROI request to emotion stage
- roi_ready in 1: emotion stage accepts ROI
- roi_x, roi_y, roi_w, roi_h out 8: ROI geometry
- busy out 1: high in every state except IDLE
- timeout_err out 1: sticky error for last frame
- frame_count out 16: completed frames

Function
REQ-003 SHALL implement states IDLE, START, STREAM, DRAIN, WAIT_DONE, REPORT.
REQ-004 IDLE: frame_ready=1 -> START; otherwise remain.
REQ-005 START: det_start=1 for exactly this one cycle; clear timeout_err; -> STREAM.
REQ-006 STREAM: mem_rd=1 every cycle, mem_addr from 0 up by 1 to IMG_WIDTH*IMG_HEIGHT-1 with no gaps; after last address -> DRAIN.
REQ-007 det_pixel_valid SHALL be mem_rd delayed one cycle, with det_pixel=mem_data registered in that cycle: exactly IMG_WIDTH*IMG_HEIGHT contiguous valid cycles per frame, raster order.
REQ-008 DRAIN (one cycle): last pixel valid; frame_release=1; -> WAIT_DONE with timeout counter cleared.
REQ-009 Timing from IDLE cycle N sampling frame_ready: det_start at N+1, first mem_rd at N+2, first det_pixel_valid at N+3, frame_release at N+2+W*H.
REQ-010 WAIT_DONE: counter increments each cycle; det_done=1 with det_face=1 -> latch ROI, -> REPORT; det_done=1 with det_face=0 -> IDLE; counter reaches TIMEOUT_CYCLES-1 without det_done -> timeout_err=1, -> IDLE; det_done wins when same cycle.
REQ-011 ROI latch: roi_x = min(det_x, IMG_WIDTH-ROI_SIZE), roi_y = min(det_y, IMG_HEIGHT-ROI_SIZE), compared unsigned at 9 bits; roi_w = roi_h = ROI_SIZE.
REQ-012 REPORT: roi_valid=1 and roi_* stable until roi_ready=1; transfer on the cycle both high (including first REPORT cycle); then -> IDLE with roi_valid=0.
REQ-013 frame_count SHALL increment by 1 on leaving WAIT_DONE (done or timeout), wrapping 0xFFFF -> 0x0000.
REQ-014 det_done outside WAIT_DONE SHALL be ignored; frame_ready outside IDLE SHALL be ignored.
REQ-015 mem_addr SHALL hold 0 when not in STREAM.

Reset
REQ-016 rst=1 SHALL at once force IDLE and all outputs to 0 (mem_addr, roi_*, frame_count, timeout_err, det_pixel included), in any state.
REQ-017 Reset mid-frame SHALL produce no frame_release and no further det_pixel_valid; next frame restarts from address 0.

Verification
REQ-018 64x64 frame, frame_ready at cycle N, det_done+det_face at 100 cycles after DRAIN with (10,20) -> 4096 contiguous pixels in order, frame_release at N+4098, roi=(10,20,24,24), frame_count=1.
REQ-019 det_face with det_x=50, det_y=63 -> roi_x=40, roi_y=40.
REQ-020 det_done never asserted -> timeout_err=1 after 65536 WAIT_DONE cycles, IDLE, frame_count increments, roi_valid never high.
REQ-021 roi_ready held low 50 cycles in REPORT -> roi_valid and roi_* stable throughout; frame_ready ignored until transfer.
REQ-022 rst pulsed at pixel 2000 -> all outputs 0 immediately; subsequent frame streams from address 0 normally.
REQ-023 det_done pulsed during STREAM, then det_face=0 done in WAIT_DONE -> early pulse ignored, no ROI, IDLE.
